// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits, odd parity, stop, ACK check.
// Optional feature macro: PS2_TX_TIMEOUT_EN adds a watchdog on device clock activity.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [3:0]    BIT_LAST = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_ACKOK,
    ST_NACK
  } state_t;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  state_t          state_q, state_d;
  logic [IW-1:0]   inh_cnt_q, inh_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      data_q, data_d;
  logic            parity_q, parity_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            busy_q, busy_d;
  logic            tx_done_q, tx_done_d;
  logic            tx_error_q, tx_error_d;
  logic            clk_oe_q, clk_oe_d;
  logic            dat_oe_q, dat_oe_d;
  logic            clk_meta_q, clk_sync_q, clk_prev_q;
  logic            dat_meta_q, dat_sync_q;
  logic            fe;
`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [19:0] WDOG_LAST = 20'(TIMEOUT_CYCLES - 1);
  logic [19:0]     wdog_q, wdog_d;
`endif

  // Pin synchronizers; reset to the idle-high bus level so no false edge follows reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_in;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign fe = clk_prev_q & ~clk_sync_q;

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    inh_cnt_d  = inh_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    parity_d   = parity_q;
    dat_oe_d   = dat_oe_q;
    tx_done_d  = 1'b0;
    tx_error_d = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    wdog_d     = wdog_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d   = ST_INHIBIT;
          inh_cnt_d = '0;
          data_d    = cmd_byte;
          parity_d  = odd_parity(cmd_byte);
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          state_d  = ST_REQ;
          dat_oe_d = 1'b1;
        end else begin
          inh_cnt_d = inh_cnt_q + IW'(1);
        end
      end
      ST_REQ: begin
        state_d   = ST_SEND;
        bit_cnt_d = 4'd0;
      end
      ST_SEND: begin
        // bit_cnt_q holds the number of device falling edges already seen
        if (fe) begin
          if (bit_cnt_q != BIT_LAST) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
          if (bit_cnt_q < 4'd8) begin
            dat_oe_d = ~data_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == 4'd8) begin
            dat_oe_d = ~parity_q;
          end else begin
            dat_oe_d = 1'b0;
            state_d  = ST_ACK;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_ACK: begin
        if (fe) begin
          state_d = dat_sync_q ? ST_NACK : ST_ACKOK;
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_ACKOK: begin
        if (clk_sync_q && dat_sync_q) begin
          state_d   = ST_IDLE;
          tx_done_d = 1'b1;
        end else begin
          state_d   = ST_ACKOK;
        end
      end
      ST_NACK: begin
        if (clk_sync_q && dat_sync_q) begin
          state_d    = ST_IDLE;
          tx_error_d = 1'b1;
        end else begin
          state_d    = ST_NACK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    if (state_q == ST_REQ) begin
      wdog_d = 20'd0;
    end else if (state_q == ST_SEND || state_q == ST_ACK ||
                 state_q == ST_ACKOK || state_q == ST_NACK) begin
      if (fe) begin
        wdog_d = 20'd0;
      end else if (wdog_q == WDOG_LAST) begin
        wdog_d     = 20'd0;
        state_d    = ST_IDLE;
        tx_done_d  = 1'b0;
        tx_error_d = 1'b1;
      end else begin
        wdog_d = wdog_q + 20'd1;
      end
    end else begin
      wdog_d = 20'd0;
    end
`endif

    // Data line is only driven during request-to-send and the bit phase
    if (state_d == ST_REQ || state_d == ST_SEND) begin
      dat_oe_d = dat_oe_d;
    end else begin
      dat_oe_d = 1'b0;
    end
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    clk_oe_d    = (state_d == ST_INHIBIT) || (state_d == ST_REQ);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      inh_cnt_q   <= '0;
      bit_cnt_q   <= 4'd0;
      data_q      <= 8'd0;
      parity_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_error_q  <= 1'b0;
      clk_oe_q    <= 1'b0;
      dat_oe_q    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wdog_q      <= 20'd0;
`endif
    end else begin
      state_q     <= state_d;
      inh_cnt_q   <= inh_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      parity_q    <= parity_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      tx_done_q   <= tx_done_d;
      tx_error_q  <= tx_error_d;
      clk_oe_q    <= clk_oe_d;
      dat_oe_q    <= dat_oe_d;
`ifdef PS2_TX_TIMEOUT_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign tx_done    = tx_done_q;
  assign tx_error   = tx_error_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule
